sram_ctrl: RTL and testbench

Synthesizable, parametrised controller for an external asynchronous SRAM (CE#/OE#/WE#/byte-enable style). Converts a single-clock request/ready bus from the NES core (PPU/CPU memory arbiter) into correctly sequenced SRAM pin activity: programmable read/write wait states, write-data hold, and bus turnaround. Replaces direct combinational pin driving; all SRAM pins come from flops.

---
 rtl/sram_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_sram_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl.sv
// sram_ctrl
// Controller for an external asynchronous SRAM (CE#/OE#/WE#/byte-lane style).
// It turns a single-clock request/ready bus into SRAM pin activity. Read and
// write wait states are programmable. Write data is held for one cycle after
// WE# rises, and a programmable number of dead cycles follows each write.
// Every SRAM pin, including the DQ driver enable, comes straight from a flop.
//
// Parameters:
//   ADDR_W   SRAM word address width
//   DATA_W   data width, a multiple of 8
//   RD_WAIT  cycles CE#/OE# are held low per read (>= 1)
//   WR_WAIT  cycles WE# is held low per write (>= 1)
//   TURN     dead cycles after a write before the next access (>= 0)
//
// Ports:
//   i_clk        system clock
//   i_rst        asynchronous active-high reset
//   i_req        access request, accepted when o_ready is high at a rising edge
//   i_we         1 = write, 0 = read (sampled with i_req)
//   i_addr       word address
//   i_wdata      write data
//   i_be         byte enables, 1 = byte written (ignored on reads)
//   o_ready      controller accepts a request this cycle (IDLE only)
//   o_rvalid     one-cycle pulse, o_rdata holds fresh read data
//   o_rdata      read data, held until the next read completes
//   o_sram_addr  SRAM address
//   o_sram_ce_n  chip enable, active-low
//   o_sram_oe_n  output enable, active-low
//   o_sram_we_n  write enable, active-low
//   o_sram_be_n  byte lane enables, active-low (bit0 = LB#, bit1 = UB# at 16 bits)
//   io_sram_dq   bidirectional SRAM data bus

module sram_ctrl #(
    parameter int ADDR_W  = 20,
    parameter int DATA_W  = 16,
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 2,
    parameter int TURN    = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req,
    input  logic                  i_we,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic [DATA_W/8-1:0]   i_be,
    output logic                  o_ready,
    output logic                  o_rvalid,
    output logic [DATA_W-1:0]     o_rdata,
    output logic [ADDR_W-1:0]     o_sram_addr,
    output logic                  o_sram_ce_n,
    output logic                  o_sram_oe_n,
    output logic                  o_sram_we_n,
    output logic [DATA_W/8-1:0]   o_sram_be_n,
    inout  wire  [DATA_W-1:0]     io_sram_dq
);

    localparam int BE_W = DATA_W / 8;

    // The wait counter only ever holds (phase length - 1), so it is sized
    // for the longest of the three programmable phases.
    localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ?
                              ((RD_WAIT > TURN) ? RD_WAIT : TURN) :
                              ((WR_WAIT > TURN) ? WR_WAIT : TURN);
    localparam int CNT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;

    localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0] WR_LAST   = CNT_W'(WR_WAIT - 1);
    localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'((TURN > 0) ? TURN - 1 : 0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_WHOLD,
        ST_TURN
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  dq_out;
    logic               dq_oe;

    // The DQ driver is enabled only from a flop. It is never set in RD, so
    // OE# and our driver cannot both be active in the same cycle.
    assign io_sram_dq = dq_oe ? dq_out : {DATA_W{1'bz}};

    // Single FSM. Each branch loads the pin registers with the values for
    // the state it is entering. The pins therefore change on the same edge
    // as the state, with no combinational path from the request bus.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            o_ready     <= 1'b1;
            o_rvalid    <= 1'b0;
            o_rdata     <= '0;
            o_sram_addr <= '0;
            o_sram_ce_n <= 1'b1;
            o_sram_oe_n <= 1'b1;
            o_sram_we_n <= 1'b1;
            o_sram_be_n <= '1;
            dq_out      <= '0;
            dq_oe       <= 1'b0;
        end else begin
            o_rvalid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_req) begin
                        o_sram_addr <= i_addr;
                        o_ready     <= 1'b0;
                        o_sram_ce_n <= 1'b0;
                        if (i_we) begin
                            state       <= ST_WR;
                            cnt         <= WR_LAST;
                            o_sram_we_n <= 1'b0;
                            o_sram_be_n <= ~i_be;
                            dq_out      <= i_wdata;
                            dq_oe       <= 1'b1;
                        end else begin
                            state       <= ST_RD;
                            cnt         <= RD_LAST;
                            o_sram_oe_n <= 1'b0;
                            o_sram_be_n <= {BE_W{1'b0}};
                        end
                    end
                end

                // The SRAM output is sampled on the edge that ends the last
                // read cycle. The result is flagged in the following IDLE
                // cycle, which can already accept the next request.
                ST_RD: begin
                    if (cnt == '0) begin
                        state       <= ST_IDLE;
                        o_rdata     <= io_sram_dq;
                        o_rvalid    <= 1'b1;
                        o_ready     <= 1'b1;
                        o_sram_ce_n <= 1'b1;
                        o_sram_oe_n <= 1'b1;
                        o_sram_be_n <= '1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                // Raising WE# while CE#, the byte lanes and DQ stay put is
                // what commits the write and gives the SRAM its hold time.
                ST_WR: begin
                    if (cnt == '0) begin
                        state       <= ST_WHOLD;
                        o_sram_we_n <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                ST_WHOLD: begin
                    o_sram_ce_n <= 1'b1;
                    o_sram_be_n <= '1;
                    dq_oe       <= 1'b0;
                    if (TURN > 0) begin
                        state <= ST_TURN;
                        cnt   <= TURN_LAST;
                    end else begin
                        state   <= ST_IDLE;
                        o_ready <= 1'b1;
                    end
                end

                ST_TURN: begin
                    if (cnt == '0) begin
                        state   <= ST_IDLE;
                        o_ready <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                default: begin
                    state       <= ST_IDLE;
                    o_ready     <= 1'b1;
                    o_sram_ce_n <= 1'b1;
                    o_sram_oe_n <= 1'b1;
                    o_sram_we_n <= 1'b1;
                    o_sram_be_n <= '1;
                    dq_oe       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl
// Self-checking bench for sram_ctrl. It contains two instances:
//   dut_a  default parameters (16-bit, RD_WAIT=2, WR_WAIT=2, TURN=1)
//   dut_b  DATA_W=32, RD_WAIT=1, WR_WAIT=3, TURN=0
// Each instance is connected to a small behavioural asynchronous SRAM model.
// The model drives DQ while CE#/OE# are low and commits each enabled byte
// lane when WE# rises.

module tb_sram_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   conflicts = 0;

    logic        req_a, we_a;
    logic [19:0] addr_a;
    logic [15:0] wdata_a;
    logic [1:0]  be_a;
    logic        ready_a, rvalid_a;
    logic [15:0] rdata_a;
    logic [19:0] sram_addr_a;
    logic        ce_n_a, oe_n_a, we_n_a;
    logic [1:0]  be_n_a;
    wire  [15:0] dq_a;
    logic [15:0] mem_a [0:255];

    logic        req_b, we_b;
    logic [19:0] addr_b;
    logic [31:0] wdata_b;
    logic [3:0]  be_b;
    logic        ready_b, rvalid_b;
    logic [31:0] rdata_b;
    logic [19:0] sram_addr_b;
    logic        ce_n_b, oe_n_b, we_n_b;
    logic [3:0]  be_n_b;
    wire  [31:0] dq_b;
    logic [31:0] mem_b [0:255];

    typedef struct {
        logic        we;
        logic [19:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        logic [15:0] exp_rdata;
        string       name;
    } vec_t;

    vec_t vecs [10];

    sram_ctrl dut_a (
        .i_clk(clk), .i_rst(rst), .i_req(req_a), .i_we(we_a),
        .i_addr(addr_a), .i_wdata(wdata_a), .i_be(be_a),
        .o_ready(ready_a), .o_rvalid(rvalid_a), .o_rdata(rdata_a),
        .o_sram_addr(sram_addr_a), .o_sram_ce_n(ce_n_a), .o_sram_oe_n(oe_n_a),
        .o_sram_we_n(we_n_a), .o_sram_be_n(be_n_a), .io_sram_dq(dq_a)
    );

    sram_ctrl #(.ADDR_W(20), .DATA_W(32), .RD_WAIT(1), .WR_WAIT(3), .TURN(0)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_req(req_b), .i_we(we_b),
        .i_addr(addr_b), .i_wdata(wdata_b), .i_be(be_b),
        .o_ready(ready_b), .o_rvalid(rvalid_b), .o_rdata(rdata_b),
        .o_sram_addr(sram_addr_b), .o_sram_ce_n(ce_n_b), .o_sram_oe_n(oe_n_b),
        .o_sram_we_n(we_n_b), .o_sram_be_n(be_n_b), .io_sram_dq(dq_b)
    );

    // 100 MHz clock. cyc counts rising edges, so a value read at a falling
    // edge is the number of the edge that started the current cycle.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Asynchronous SRAM models. They drive on read and commit byte lanes on
    // the WE# rising edge. A WE# rise caused by reset is ignored, so an
    // aborted write cannot land on whatever address reset leaves behind.
    assign dq_a = (!ce_n_a && !oe_n_a && we_n_a) ? mem_a[sram_addr_a[7:0]] : 16'hzzzz;
    assign dq_b = (!ce_n_b && !oe_n_b && we_n_b) ? mem_b[sram_addr_b[7:0]] : 32'hzzzz_zzzz;

    always @(posedge we_n_a) begin
        if (!ce_n_a && !rst) begin
            for (int b = 0; b < 2; b++)
                if (!be_n_a[b]) mem_a[sram_addr_a[7:0]][8*b +: 8] <= dq_a[8*b +: 8];
        end
    end

    always @(posedge we_n_b) begin
        if (!ce_n_b && !rst) begin
            for (int b = 0; b < 4; b++)
                if (!be_n_b[b]) mem_b[sram_addr_b[7:0]][8*b +: 8] <= dq_b[8*b +: 8];
        end
    end

    // Count every cycle in which OE# is low while the controller drives DQ.
    always @(negedge clk) begin
        conflicts <= conflicts + int'(!oe_n_a && dut_a.dq_oe) + int'(!oe_n_b && dut_b.dq_oe);
    end

    // Watchdog so the run always ends even if a handshake locks up.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required earlier finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name, input int waited);
        tests++;
        fails++;
        $display("[TB] FAIL %s: no response after %0d cycles, expected within 50", name, waited);
    endtask

    // One access on dut_a, called at a falling edge. The task presents the
    // request, waits for it to be accepted, then waits for completion:
    // o_ready back high for a write, o_rvalid for a read. It returns the
    // accept edge, ready-low and WE#-low cycle counts, the read data and
    // the edge that started the o_rvalid cycle. With hold set, i_req stays
    // high on return, so the caller's next access is accepted without a
    // gap.
    task automatic applyStimulus(input logic we, input logic [19:0] addr, input logic [15:0] wdata,
                                 input logic [1:0] be, input bit hold,
                                 output int acc, output int low, output int welow,
                                 output logic [15:0] rdata, output int rv);
        int g;
        req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wdata; be_a = be;
        g = 0;
        while (!ready_a && g < 50) begin @(negedge clk); g++; end
        if (g >= 50) reportTimeout("a_accept", g);
        acc = cyc + 1;
        @(negedge clk);
        low = 0; welow = 0; g = 0;
        while (!(we ? ready_a : rvalid_a) && g < 50) begin
            if (!ready_a) low++;
            if (!we_n_a) welow++;
            @(negedge clk);
            g++;
        end
        if (g >= 50) reportTimeout("a_complete", g);
        rv = cyc;
        rdata = rdata_a;
        if (!hold) req_a = 1'b0;
    endtask

    task automatic applyStimulusB(input logic we, input logic [19:0] addr, input logic [31:0] wdata,
                                  input logic [3:0] be, input bit hold,
                                  output int acc, output int low, output int welow,
                                  output logic [31:0] rdata, output int rv);
        int g;
        req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wdata; be_b = be;
        g = 0;
        while (!ready_b && g < 50) begin @(negedge clk); g++; end
        if (g >= 50) reportTimeout("b_accept", g);
        acc = cyc + 1;
        @(negedge clk);
        low = 0; welow = 0; g = 0;
        while (!(we ? ready_b : rvalid_b) && g < 50) begin
            if (!ready_b) low++;
            if (!we_n_b) welow++;
            @(negedge clk);
            g++;
        end
        if (g >= 50) reportTimeout("b_complete", g);
        rv = cyc;
        rdata = rdata_b;
        if (!hold) req_b = 1'b0;
    endtask

    initial begin
        int          acc, low, welow, rv, acc_prev;
        int          accs [3];
        logic [15:0] rd;
        logic [31:0] rdw;

        // Expected o_rdata after each access: the read result for reads,
        // and the unchanged previous read value for writes.
        vecs[0] = '{1'b1, 20'h00123, 16'hBEEF, 2'b11, 16'h0000, "wr_beef"};
        vecs[1] = '{1'b0, 20'h00123, 16'h0000, 2'b00, 16'hBEEF, "rd_beef"};
        vecs[2] = '{1'b1, 20'h00010, 16'h1234, 2'b11, 16'hBEEF, "wr_1234"};
        vecs[3] = '{1'b1, 20'h00010, 16'hAB00, 2'b10, 16'hBEEF, "wr_hi_ab"};
        vecs[4] = '{1'b0, 20'h00010, 16'h0000, 2'b11, 16'hAB34, "rd_ab34"};
        vecs[5] = '{1'b1, 20'h00010, 16'hFFFF, 2'b00, 16'hAB34, "wr_be0"};
        vecs[6] = '{1'b0, 20'h00010, 16'h0000, 2'b00, 16'hAB34, "rd_ab34_again"};
        vecs[7] = '{1'b1, 20'h00000, 16'h1111, 2'b11, 16'hAB34, "wr_0"};
        vecs[8] = '{1'b1, 20'h00001, 16'h2222, 2'b11, 16'hAB34, "wr_1"};
        vecs[9] = '{1'b1, 20'h00002, 16'h3333, 2'b11, 16'hAB34, "wr_2"};

        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 16'h0000;
            mem_b[i] = 32'h0000_0000;
        end
        req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0; be_a = '0;
        req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0; be_b = '0;

        // Power-on reset.
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("por_ready", 32'(ready_a), 32'h1);
        checkOutput("por_rvalid", 32'(rvalid_a), 32'h0);
        checkOutput("por_ctrl", {29'h0, ce_n_a, oe_n_a, we_n_a}, 32'h7);
        checkOutput("por_be_n", 32'(be_n_a), 32'h3);
        checkOutput("por_dq_oe", 32'(dut_a.dq_oe), 32'h0);
        checkOutput("por_rdata", 32'(rdata_a), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Table of single accesses with their timing.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, 1'b0,
                          acc, low, welow, rd, rv);
            checkOutput({vecs[i].name, "_rdata"}, 32'(rd), 32'(vecs[i].exp_rdata));
            if (vecs[i].we) begin
                checkOutput({vecs[i].name, "_ready_low"}, 32'(low), 32'd4);
                checkOutput({vecs[i].name, "_we_low"}, 32'(welow), 32'd2);
            end else begin
                checkOutput({vecs[i].name, "_latency"}, 32'(rv - acc + 1), 32'd3);
                checkOutput({vecs[i].name, "_ready_low"}, 32'(low), 32'd2);
            end
        end

        // Back-to-back reads with i_req held high throughout.
        for (int n = 0; n < 3; n++) begin
            applyStimulus(1'b0, 20'(n), 16'h0, 2'b00, (n < 2), acc, low, welow, rd, rv);
            accs[n] = acc;
            checkOutput($sformatf("b2b_rd%0d_data", n), 32'(rd), 32'h1111 * (n + 1));
        end
        checkOutput("b2b_period_01", 32'(accs[1] - accs[0]), 32'd3);
        checkOutput("b2b_period_12", 32'(accs[2] - accs[1]), 32'd3);

        // Write followed by an immediate read of the same word.
        applyStimulus(1'b1, 20'h00005, 16'h5555, 2'b11, 1'b1, acc, low, welow, rd, rv);
        acc_prev = acc;
        checkOutput("wr_rd_ready_low", 32'(low), 32'd4);
        applyStimulus(1'b0, 20'h00005, 16'h0, 2'b00, 1'b0, acc, low, welow, rd, rv);
        checkOutput("wr_rd_period", 32'(acc - acc_prev), 32'd5);
        checkOutput("wr_rd_data", 32'(rd), 32'h5555);

        // Reset in the middle of a read, away from any clock edge.
        req_a = 1'b1; we_a = 1'b0; addr_a = 20'h00010;
        @(negedge clk);
        req_a = 1'b0;
        checkOutput("mid_rd_oe_active", 32'(oe_n_a), 32'h0);
        #2 rst = 1'b1;
        #1;
        checkOutput("mid_rd_rst_ctrl", {29'h0, ce_n_a, oe_n_a, we_n_a}, 32'h7);
        checkOutput("mid_rd_rst_ready", 32'(ready_a), 32'h1);
        checkOutput("mid_rd_rst_rdata", 32'(rdata_a), 32'h0);
        checkOutput("mid_rd_rst_addr", 32'(sram_addr_a), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset after one WE# low cycle of a write.
        req_a = 1'b1; we_a = 1'b1; addr_a = 20'h00123; wdata_a = 16'h0BAD; be_a = 2'b11;
        @(negedge clk);
        req_a = 1'b0;
        checkOutput("mid_wr_we_active", 32'(we_n_a), 32'h0);
        checkOutput("mid_wr_dq_driven", 32'(dut_a.dq_oe), 32'h1);
        #2 rst = 1'b1;
        #1;
        checkOutput("mid_wr_rst_ctrl", {29'h0, ce_n_a, oe_n_a, we_n_a}, 32'h7);
        checkOutput("mid_wr_rst_be_n", 32'(be_n_a), 32'h3);
        checkOutput("mid_wr_rst_dq_oe", 32'(dut_a.dq_oe), 32'h0);
        checkOutput("mid_wr_rst_rvalid", 32'(rvalid_a), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        applyStimulus(1'b0, 20'h00010, 16'h0, 2'b00, 1'b0, acc, low, welow, rd, rv);
        checkOutput("post_rst_rd_10", 32'(rd), 32'hAB34);
        applyStimulus(1'b0, 20'h00001, 16'h0, 2'b00, 1'b0, acc, low, welow, rd, rv);
        checkOutput("post_rst_rd_1", 32'(rd), 32'h2222);

        // 32-bit instance: RD_WAIT=1, WR_WAIT=3, TURN=0.
        applyStimulusB(1'b1, 20'h00040, 32'hDEADBEEF, 4'b1111, 1'b1, acc, low, welow, rdw, rv);
        acc_prev = acc;
        checkOutput("b_wr_ready_low", 32'(low), 32'd4);
        checkOutput("b_wr_we_low", 32'(welow), 32'd3);
        applyStimulusB(1'b1, 20'h00041, 32'h0BADF00D, 4'b0101, 1'b1, acc, low, welow, rdw, rv);
        checkOutput("b_wr_period", 32'(acc - acc_prev), 32'd5);
        acc_prev = acc;
        applyStimulusB(1'b0, 20'h00040, 32'h0, 4'b0000, 1'b1, acc, low, welow, rdw, rv);
        checkOutput("b_wr_rd_period", 32'(acc - acc_prev), 32'd5);
        checkOutput("b_rd_data", rdw, 32'hDEADBEEF);
        checkOutput("b_rd_latency", 32'(rv - acc + 1), 32'd2);
        acc_prev = acc;
        applyStimulusB(1'b0, 20'h00041, 32'h0, 4'b0000, 1'b0, acc, low, welow, rdw, rv);
        checkOutput("b_rd_period", 32'(acc - acc_prev), 32'd2);
        checkOutput("b_rd_lanes", rdw, 32'h00AD000D);

        repeat (2) @(negedge clk);
        checkOutput("no_bus_conflict", 32'(conflicts), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
